// File: rtl/gpio_multi_ctrl_if.sv
// CPU data-bus port of the GPIO controller: write/read strobes, word address and data.
interface gpio_multi_ctrl_if;
  logic [31:0] DATA_I;
  logic [31:0] DATA_O;
  logic [31:0] ADDR;
  logic        WRSTB;
  logic        RDSTB;

  modport master (output DATA_I, ADDR, WRSTB, RDSTB, input DATA_O);
  modport slave  (input DATA_I, ADDR, WRSTB, RDSTB, output DATA_O);
endinterface

// File: rtl/gpio_multi_ctrl.sv
// Multi-channel memory-mapped GPIO: OUT/DIR registers, synchronised and debounced
// inputs, atomic set/clear and rising-edge interrupts with W1C status.
module gpio_multi_ctrl #(
  parameter logic [31:0] BASEADDRESS = 32'h8000_0000,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CH_WIDTH    = 32,
  parameter int unsigned DEBOUNCE    = 16
) (
  input  logic                       ACLK,
  input  logic                       RESET,
  gpio_multi_ctrl_if.slave           bus,
  input  logic [NUM_CH*CH_WIDTH-1:0] GPIO_IN,
  output logic [NUM_CH*CH_WIDTH-1:0] GPIO_OUT,
  output logic [NUM_CH*CH_WIDTH-1:0] GPIO_OE,
  output logic                       IRQ
);
  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  typedef logic [CH_WIDTH-1:0] ch_t;

  ch_t out_q[NUM_CH], out_d[NUM_CH];
  ch_t dir_q[NUM_CH], dir_d[NUM_CH];
  ch_t ien_q[NUM_CH], ien_d[NUM_CH];
  ch_t ist_q[NUM_CH], ist_d[NUM_CH];
  ch_t sync1_q[NUM_CH], sync1_d[NUM_CH];
  ch_t sync2_q[NUM_CH], sync2_d[NUM_CH];
  ch_t smp_q[NUM_CH], smp_d[NUM_CH];
  ch_t deb_q[NUM_CH], deb_d[NUM_CH];
  ch_t deb_prev_q[NUM_CH], deb_prev_d[NUM_CH];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;

  logic [31:0] off;
  logic        hit;
  logic [2:0]  ch_sel, reg_sel;
  logic        tick;
  ch_t         wdata;

  assign off     = bus.ADDR - BASEADDRESS;
  assign hit     = (bus.ADDR >= BASEADDRESS) && (off < 32'(NUM_CH * 32));
  assign ch_sel  = off[7:5];
  assign reg_sel = off[4:2];
  assign wdata   = bus.DATA_I[CH_WIDTH-1:0];

  // Free-running sample-tick counter shared by all pins.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b1;
    if (DEBOUNCE > 1) begin
      tick  = (cnt_q == CntW'(DEBOUNCE - 1));
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_comb begin
    ch_t rise;
    ch_t w1c;
    rdata_d = rdata_q;
    irq_d   = 1'b0;
    if (bus.RDSTB) rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_d[c]      = out_q[c];
      dir_d[c]      = dir_q[c];
      ien_d[c]      = ien_q[c];
      sync1_d[c]    = GPIO_IN[c*CH_WIDTH +: CH_WIDTH];
      sync2_d[c]    = sync1_q[c];
      smp_d[c]      = smp_q[c];
      deb_d[c]      = deb_q[c];
      deb_prev_d[c] = deb_q[c];
      w1c           = '0;
      rise          = deb_q[c] & ~deb_prev_q[c];

      if (DEBOUNCE == 0) begin
        deb_d[c] = sync2_q[c];
      end else if (tick) begin
        // Accept a level only after two consecutive ticks agree.
        smp_d[c] = sync2_q[c];
        if (sync2_q[c] == smp_q[c]) deb_d[c] = sync2_q[c];
      end

      if (bus.WRSTB && hit && (ch_sel == 3'(c))) begin
        case (reg_sel)
          3'd0:    out_d[c] = wdata;
          3'd1:    dir_d[c] = wdata;
          3'd3:    ien_d[c] = wdata;
          3'd4:    w1c      = wdata;
          3'd5:    out_d[c] = out_q[c] | wdata;
          3'd6:    out_d[c] = out_q[c] & ~wdata;
          default: ;
        endcase
      end
      // A new edge wins over a coincident clear.
      ist_d[c] = (ist_q[c] & ~w1c) | (rise & ien_q[c]);
      irq_d    = irq_d | (|(ist_q[c] & ien_q[c]));

      if (bus.RDSTB && hit && (ch_sel == 3'(c))) begin
        case (reg_sel)
          3'd0:    rdata_d = 32'(out_q[c]);
          3'd1:    rdata_d = 32'(dir_q[c]);
          3'd2:    rdata_d = 32'(deb_q[c]);
          3'd3:    rdata_d = 32'(ien_q[c]);
          3'd4:    rdata_d = 32'(ist_q[c]);
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c]      <= '0;
        dir_q[c]      <= '0;
        ien_q[c]      <= '0;
        ist_q[c]      <= '0;
        sync1_q[c]    <= '0;
        sync2_q[c]    <= '0;
        smp_q[c]      <= '0;
        deb_q[c]      <= '0;
        deb_prev_q[c] <= '0;
      end
      cnt_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c]      <= out_d[c];
        dir_q[c]      <= dir_d[c];
        ien_q[c]      <= ien_d[c];
        ist_q[c]      <= ist_d[c];
        sync1_q[c]    <= sync1_d[c];
        sync2_q[c]    <= sync2_d[c];
        smp_q[c]      <= smp_d[c];
        deb_q[c]      <= deb_d[c];
        deb_prev_q[c] <= deb_prev_d[c];
      end
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    GPIO_OUT = '0;
    GPIO_OE  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      GPIO_OUT[c*CH_WIDTH +: CH_WIDTH] = out_q[c];
      GPIO_OE[c*CH_WIDTH +: CH_WIDTH]  = dir_q[c];
    end
  end

  assign bus.DATA_O = rdata_q;
  assign IRQ        = irq_q;
endmodule

// File: tb/tb_gpio_multi_ctrl.sv
// Directed-vector bench for gpio_multi_ctrl (2 channels x 32 pins, DEBOUNCE = 4).
module tb_gpio_multi_ctrl;
  localparam int unsigned NumCh = 2;
  localparam int unsigned ChW   = 32;
  localparam int unsigned Deb   = 4;

  logic        ACLK = 1'b0;
  logic        RESET;
  logic [63:0] gpio_in;
  logic [63:0] gpio_out;
  logic [63:0] gpio_oe;
  logic        irq;
  int unsigned cyc;
  int          n_vec = 0;
  int          n_err = 0;

  gpio_multi_ctrl_if bus_if ();

  gpio_multi_ctrl #(
    .BASEADDRESS(32'h8000_0000),
    .NUM_CH     (NumCh),
    .CH_WIDTH   (ChW),
    .DEBOUNCE   (Deb)
  ) dut (
    .ACLK    (ACLK),
    .RESET   (RESET),
    .bus     (bus_if),
    .GPIO_IN (gpio_in),
    .GPIO_OUT(gpio_out),
    .GPIO_OE (gpio_oe),
    .IRQ     (irq)
  );

  always #5 ACLK = ~ACLK;

  // Cycles since reset release; tracks the debounce tick phase (tick when cyc % 4 == 3).
  always @(posedge ACLK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Both tasks start and end on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.ADDR   = a;
    bus_if.DATA_I = d;
    bus_if.WRSTB  = 1'b1;
    @(negedge ACLK);
    bus_if.WRSTB  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.ADDR  = a;
    bus_if.RDSTB = 1'b1;
    @(negedge ACLK);
    bus_if.RDSTB = 1'b0;
    d = bus_if.DATA_O;
  endtask

  initial begin
    logic [31:0] rd;
    int unsigned n;
    RESET         = 1'b1;
    gpio_in       = '0;
    bus_if.ADDR   = '0;
    bus_if.DATA_I = '0;
    bus_if.WRSTB  = 1'b0;
    bus_if.RDSTB  = 1'b0;
    repeat (2) @(negedge ACLK);
    check("rst_out", gpio_out, 64'h0);
    check("rst_oe", gpio_oe, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    check("rst_rdata", {32'h0, bus_if.DATA_O}, 64'h0);
    RESET = 1'b0;
    @(negedge ACLK);

    // OUT write, then atomic set and clear on channel 1.
    bus_write(32'h8000_0020, 32'hA5A5_0F0F);
    check("out_wr", gpio_out, 64'hA5A5_0F0F_0000_0000);
    bus_write(32'h8000_0034, 32'h0000_00F0);
    bus_write(32'h8000_0038, 32'h0000_000F);
    check("set_clr", gpio_out, 64'hA5A5_0FF0_0000_0000);
    bus_read(32'h8000_0020, rd);
    check("rd_out1", {32'h0, rd}, 64'hA5A5_0FF0);
    bus_read(32'h8000_0034, rd);
    check("rd_set", {32'h0, rd}, 64'h0);

    bus_write(32'h8000_0004, 32'h0000_FFFF);
    check("dir_oe", gpio_oe, 64'h0000_0000_0000_FFFF);
    bus_read(32'h8000_0004, rd);
    check("rd_dir0", {32'h0, rd}, 64'h0000_FFFF);

    // 3-cycle glitch is rejected by the debouncer.
    gpio_in[0] = 1'b1;
    repeat (3) @(negedge ACLK);
    gpio_in[0] = 1'b0;
    repeat (20) @(negedge ACLK);
    bus_read(32'h8000_0008, rd);
    check("glitch_in", {32'h0, rd}, 64'h0);

    // Held level shows up within 14 cycles; no interrupt while disabled.
    gpio_in[0] = 1'b1;
    repeat (13) @(negedge ACLK);
    bus_read(32'h8000_0008, rd);
    check("deb_in", {32'h0, rd}, 64'h1);
    check("irq_dis", {63'h0, irq}, 64'h0);
    bus_read(32'h8000_0010, rd);
    check("ist_dis", {32'h0, rd}, 64'h0);

    // Enabling after the edge must not flag it.
    bus_write(32'h8000_000C, 32'h1);
    repeat (10) @(negedge ACLK);
    bus_read(32'h8000_0010, rd);
    check("ist_old_edge", {32'h0, rd}, 64'h0);
    check("irq_old_edge", {63'h0, irq}, 64'h0);

    // Fresh rising edge raises status and IRQ; W1C drops IRQ one cycle later.
    gpio_in[0] = 1'b0;
    repeat (20) @(negedge ACLK);
    gpio_in[0] = 1'b1;
    for (int i = 0; i < 30 && !irq; i++) @(negedge ACLK);
    check("irq_edge", {63'h0, irq}, 64'h1);
    bus_read(32'h8000_0010, rd);
    check("ist_edge", {32'h0, rd}, 64'h1);
    bus_write(32'h8000_0010, 32'h1);
    check("irq_hold", {63'h0, irq}, 64'h1);
    @(negedge ACLK);
    check("irq_w1c", {63'h0, irq}, 64'h0);

    // Clear coincident with a new edge: align to tick phase so the rise lands at cyc n+8.
    gpio_in[0] = 1'b0;
    repeat (20) @(negedge ACLK);
    while (cyc % 4 != 0) @(negedge ACLK);
    gpio_in[0] = 1'b1;
    n = cyc;
    while (cyc != n + 8) @(negedge ACLK);
    bus_write(32'h8000_0010, 32'h1);
    bus_read(32'h8000_0010, rd);
    check("ist_set_wins", {32'h0, rd}, 64'h1);
    check("irq_set_wins", {63'h0, irq}, 64'h1);

    // Out-of-range accesses are ignored and read back zero.
    bus_write(32'h8000_0040, 32'hFFFF_FFFF);
    bus_write(32'h7FFF_FFFC, 32'hFFFF_FFFF);
    check("oor_out", gpio_out, 64'hA5A5_0FF0_0000_0000);
    check("oor_oe", gpio_oe, 64'h0000_0000_0000_FFFF);
    bus_read(32'h8000_0020, rd);
    bus_read(32'h8000_0040, rd);
    check("rd_oor_hi", {32'h0, rd}, 64'h0);
    bus_read(32'h8000_0020, rd);
    bus_read(32'h7FFF_FFFC, rd);
    check("rd_oor_lo", {32'h0, rd}, 64'h0);
    bus_read(32'h8000_0020, rd);
    bus_read(32'h8000_001C, rd);
    check("rd_rsvd", {32'h0, rd}, 64'h0);

    // Read and write to the same register in one cycle returns the old value.
    bus_if.ADDR   = 32'h8000_0000;
    bus_if.DATA_I = 32'h1234_5678;
    bus_if.WRSTB  = 1'b1;
    bus_if.RDSTB  = 1'b1;
    @(negedge ACLK);
    bus_if.WRSTB  = 1'b0;
    bus_if.RDSTB  = 1'b0;
    check("rw_old", {32'h0, bus_if.DATA_O}, 64'h0);
    check("rw_new", gpio_out, 64'hA5A5_0FF0_1234_5678);

    // Asynchronous reset mid-operation clears outputs before any clock edge.
    bus_read(32'h8000_0020, rd);
    check("pre_rst_rd", {32'h0, rd}, 64'hA5A5_0FF0);
    #2 RESET = 1'b1;
    #1;
    check("arst_out", gpio_out, 64'h0);
    check("arst_oe", gpio_oe, 64'h0);
    check("arst_irq", {63'h0, irq}, 64'h0);
    check("arst_rdata", {32'h0, bus_if.DATA_O}, 64'h0);
    @(negedge ACLK);
    RESET = 1'b0;
    @(negedge ACLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
